imm_ext_ctrl: RTL
=================

// Module: imm_ext_ctrl
//
// PURPOSE
//  Decode-stage immediate controller for the Antares-R2 datapath. Accepts fetched
//  instruction words over a valid/ready handshake and selects the extension mode
//  from the opcode: sign, zero, upper or branch. Produces the 32-bit operand.
//  A 2-entry skid buffer decouples fetch from execute back-pressure.
//  Sits between the IF/ID register and the ALU operand mux, replacing the fixed
//  sign extender on the immediate path.
//
// PARAMETERS
//  DATA_W  32  width of out_imm and of the instruction word
//  IMM_W   16  immediate field width, instr[IMM_W-1:0]
//  TAG_W   8   width of the sideband tag (PC index) carried with each entry
//
// PORTS
//  clock      in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  flush      in   1       drop all buffered entries (branch taken / exception)
//  in_valid   in   1       instruction word present
//  in_ready   out  1       buffer can accept; equals (state != FULL)
//  in_instr   in   DATA_W  instruction word; opcode = in_instr[31:26]
//  in_tag     in   TAG_W   sideband tag, returned unchanged
//  out_valid  out  1       head entry valid
//  out_ready  in   1       consumer takes head entry
//  out_imm    out  DATA_W  extended immediate
//  out_mode   out  3       imm_mode_t: NONE=0 SEXT=1 ZEXT=2 UPPER=3 BRANCH=4
//  out_tag    out  TAG_W   tag of head entry
//
// BEHAVIOUR
//  - Transfer: in on (in_valid & in_ready); out on (out_valid & out_ready), at the clock edge.
//  - Decode is combinational at input; results are written into the buffer, so latency is 1 cycle.
//  - Throughput: 1 entry/cycle sustained; simultaneous push and pop leave occupancy unchanged.
//  - Opcode map: 0x08-0x0B, 0x23, 0x2B -> SEXT; 0x0C-0x0E -> ZEXT;
//    0x0F -> UPPER; 0x04, 0x05 -> BRANCH; all others, including 0x00 and 0x02/0x03 -> NONE.
//  - Results per mode, with imm = instr[15:0]:
//    - SEXT: {16{imm[15]}, imm}.
//    - ZEXT: {16'b0, imm}.
//    - UPPER: {imm, 16'b0}.
//    - BRANCH: SEXT result shifted left 2; bits shifted out are discarded.
//    - NONE: 0.
//  - FSM states EMPTY, ONE, FULL:
//    - EMPTY --push--> ONE.
//    - ONE --push, no pop--> FULL.
//    - ONE --pop, no push--> EMPTY.
//    - ONE --push & pop--> ONE.
//    - FULL --pop--> ONE. No push is possible in FULL because in_ready=0.
//  - Ordering: FIFO. The head is always slot 0; on a pop, slot 1 moves to slot 0.
//  - out_* are stable while out_valid=1 and out_ready=0.
//  - flush has priority over everything. At the next edge the state becomes EMPTY and any
//    same-cycle push or pop is discarded. in_ready stays as derived from state in the flush cycle.
//  - Reset (async, mid-operation too) -> state EMPTY, out_valid=0, out_imm=0, out_mode=NONE,
//    out_tag=0, in_ready=1. Buffered entries are lost.
//  - out_imm/out_mode/out_tag read 0 whenever out_valid=0.
//
// CONFIGURATION
//  IMM_ZERO_EXT_EN defined: opcodes 0x0C-0x0E decode to ZEXT as mapped above.
//  IMM_ZERO_EXT_EN undefined: 0x0C-0x0E decode to SEXT. ZEXT is never produced, and the
//    enum value 2 is unused.
//
// STRUCTURE
//  - Package imm_ext_pkg:
//    - imm_mode_t enum.
//    - opcode localparams: OP_ADDI..OP_LUI, OP_BEQ, OP_BNE, OP_LW, OP_SW.
//    - buf_state_t {EMPTY, ONE, FULL}.
//    - entry struct {imm, mode, tag}.
//  - Sub-module imm_ext_decode: combinational opcode+imm -> {mode, imm}. It holds the
//    IMM_ZERO_EXT_EN guard. The top holds the skid buffer and the FSM.
//
// TESTING
//  1. instr 0x2008FFFC (ADDI), out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFC, mode=SEXT.
//  2. instr 0x3508FFFF (ORI) -> imm=0x0000FFFF, mode=ZEXT; without the macro
//     -> imm=0xFFFFFFFF, mode=SEXT.
//  3. 0x3C081234 (LUI) -> 0x12340000 UPPER. 0x1108FFFF (BEQ) -> 0xFFFFFFFC BRANCH.
//     0x01095020 (R-type) -> 0, NONE.
//  4. Hold out_ready=0 and push 3 words (tags 1,2,3) -> in_ready drops after 2 and tag 3 is
//     held off. Then release -> tags 1,2,3 drain in order, one per cycle.
//  5. FULL, then flush together with in_valid=1 and out_ready=1 -> next cycle out_valid=0,
//     in_ready=1, no entry accepted or popped.
//  6. Assert reset asynchronously mid-burst between edges -> outputs go to 0/NONE at once and
//     in_ready=1. The first word after release arrives with 1-cycle latency.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared types for the decode-stage immediate controller.
// Holds modes, opcodes, buffer states and the buffer entry layout.
package imm_ext_pkg;

    localparam int ENT_DATA_W = 32;
    localparam int ENT_TAG_W  = 8;
    localparam int OP_W       = 6;

    typedef enum logic [2:0] {
        MODE_NONE   = 3'd0,
        MODE_SEXT   = 3'd1,
        MODE_ZEXT   = 3'd2,
        MODE_UPPER  = 3'd3,
        MODE_BRANCH = 3'd4
    } imm_mode_t;

    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [ENT_DATA_W-1:0] imm;
        imm_mode_t             mode;
        logic [ENT_TAG_W-1:0]  tag;
    } entry_t;

endpackage

// File: rtl/imm_ext_decode.sv
// Combinational opcode + immediate field -> extension mode and operand.
// Ports: opcode (in), imm_field (in), mode (out), imm (out).
// Macro IMM_ZERO_EXT_EN: logical-immediate opcodes zero-extend;
// when undefined they sign-extend and MODE_ZEXT never appears.
module imm_ext_decode
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [OP_W-1:0]   opcode,
    input  logic [IMM_W-1:0]  imm_field,
    output imm_mode_t         mode,
    output logic [DATA_W-1:0] imm
);

`ifdef IMM_ZERO_EXT_EN
    localparam imm_mode_t LOGIC_MODE = MODE_ZEXT;
`else
    localparam imm_mode_t LOGIC_MODE = MODE_SEXT;
`endif

    logic is_sext;
    logic is_zext;
    logic is_upper;
    logic is_branch;

    assign is_sext   = opcode inside {OP_ADDI, OP_ADDIU, OP_SLTI,
                                      OP_SLTIU, OP_LW, OP_SW};
    assign is_zext   = opcode inside {OP_ANDI, OP_ORI, OP_XORI};
    assign is_upper  = (opcode == OP_LUI);
    assign is_branch = opcode inside {OP_BEQ, OP_BNE};

    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] zext;
    logic [DATA_W-1:0] upper;
    logic [DATA_W-1:0] branch;

    assign sext   = {{(DATA_W-IMM_W){imm_field[IMM_W-1]}}, imm_field};
    assign zext   = {{(DATA_W-IMM_W){1'b0}}, imm_field};
    assign upper  = {imm_field, {(DATA_W-IMM_W){1'b0}}};
    // Word offset: the top two sign bits fall off the end.
    assign branch = {sext[DATA_W-3:0], 2'b00};

    always_comb begin
        mode = MODE_NONE;
        unique case (1'b1)
            is_sext:   mode = MODE_SEXT;
            is_zext:   mode = LOGIC_MODE;
            is_upper:  mode = MODE_UPPER;
            is_branch: mode = MODE_BRANCH;
            default:   mode = MODE_NONE;
        endcase
    end

    always_comb begin
        imm = '0;
        unique case (mode)
            MODE_SEXT:   imm = sext;
            MODE_ZEXT:   imm = zext;
            MODE_UPPER:  imm = upper;
            MODE_BRANCH: imm = branch;
            default:     imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_ext_ctrl.sv
// Decode-stage immediate controller with a 2-entry skid buffer.
// Ports: clock, reset (async, active-high), flush; in_valid/in_ready,
//   in_instr, in_tag; out_valid/out_ready, out_imm, out_mode, out_tag.
// Macro IMM_ZERO_EXT_EN: see imm_ext_decode.
module imm_ext_ctrl
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = ENT_DATA_W,
    parameter int IMM_W  = 16,
    parameter int TAG_W  = ENT_TAG_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic [2:0]        out_mode,
    output logic [TAG_W-1:0]  out_tag
);

    buf_state_t        state;
    entry_t            slot0;
    entry_t            slot1;
    entry_t            din;
    imm_mode_t         dec_mode;
    logic [DATA_W-1:0] dec_imm;
    logic              push;
    logic              pop;

    // Fields between the opcode and the immediate are not used here.
    logic unused_bits;
    assign unused_bits = ^in_instr[DATA_W-OP_W-1:IMM_W];

    imm_ext_decode #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_decode (
        .opcode    (in_instr[DATA_W-1 -: OP_W]),
        .imm_field (in_instr[IMM_W-1:0]),
        .mode      (dec_mode),
        .imm       (dec_imm)
    );

    assign din = '{imm: dec_imm, mode: dec_mode, tag: in_tag};

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_imm  = out_valid ? slot0.imm : '0;
    assign out_mode = out_valid ? slot0.mode : MODE_NONE;
    assign out_tag  = out_valid ? slot0.tag : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        slot0 <= din;
                        state <= ONE;
                    end
                end
                ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            slot1 <= din;
                            state <= FULL;
                        end
                        2'b01: state <= EMPTY;
                        // Head leaves and the new word takes its place.
                        2'b11: slot0 <= din;
                        default: ;
                    endcase
                end
                FULL: begin
                    if (pop) begin
                        slot0 <= slot1;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule
